// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready command into AW/W/B or AR/R
// traffic and hands the write response or read data back on a valid/ready response port.
module axi4lite_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_AW_W = 3'd1;
  localparam logic [2:0] S_WR_B    = 3'd2;
  localparam logic [2:0] S_RD_AR   = 3'd3;
  localparam logic [2:0] S_RD_R    = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]            r_state;
  logic                  r_cmd_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  logic w_aw_fin;
  logic w_w_fin;

  // AW and W complete independently; either may finish first or both on the same edge
  assign w_aw_fin = r_aw_done | (r_awvalid & m_axi_awready);
  assign w_w_fin  = r_w_done  | (r_wvalid  & m_axi_wready);

  // Transaction FSM; every output is a flop so no input reaches an output combinationally
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= {DATA_WIDTH{1'b0}};
      r_rsp_resp  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            if (cmd_write) begin
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_AW_W;
            end else begin
              r_wdata   <= {DATA_WIDTH{1'b0}};
              r_arvalid <= 1'b1;
              r_state   <= S_RD_AR;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_WR_AW_W: begin
          if (r_awvalid && m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && m_axi_wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (m_axi_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
            r_rsp_resp  <= m_axi_bresp;
            r_state     <= S_RSP;
          end
        end
        S_RD_AR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (m_axi_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= m_axi_rdata;
            r_rsp_resp  <= 2'b00;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          // rsp_* stay frozen until the consumer takes them
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_aw_done   <= 1'b0;
          r_w_done    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: behavioural AXI4-Lite slave with programmable ready delays,
// scoreboard of expected responses, protocol monitors for valid stability and outstanding count.
`timescale 1ns/1ps
module tb_axi4lite_master;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp;

  always #5 clk = ~clk;

  axi4lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] s_mem [0:15];
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic        b_block = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic [5:0]  s_awaddr = 6'd0;
  logic [31:0] s_wdata = 32'd0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [5:0]  s_addr_now;
  logic [31:0] s_data_now;
  logic        s_aw_now, s_w_now;

  assign awready    = (aw_cnt >= aw_delay) && !aw_got && !bvalid;
  assign wready     = (w_cnt >= w_delay) && !w_got && !bvalid;
  assign arready    = (ar_cnt >= ar_delay) && !rvalid;
  assign s_aw_now   = aw_got || (awvalid && awready);
  assign s_w_now    = w_got || (wvalid && wready);
  assign s_addr_now = aw_got ? s_awaddr : awaddr;
  assign s_data_now = w_got ? s_wdata : wdata;

  always @(posedge clk) begin
    if (!aresetn) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rdata <= 32'd0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0; aw_hs <= aw_hs + 1;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        w_got <= 1'b1; s_wdata <= wdata; w_cnt <= 0; w_hs <= w_hs + 1;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if (!bvalid && !b_block && s_aw_now && s_w_now) begin
        bvalid <= 1'b1; bresp <= b_resp_cfg;
        s_mem[s_addr_now[5:2]] <= s_data_now;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= s_mem[araddr[5:2]]; ar_cnt <= 0; ar_hs <= ar_hs + 1;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready) begin rvalid <= 1'b0; r_hs <= r_hs + 1; end
    end
  end

  // ---------------- protocol monitor ----------------
  int          out_cnt = 0, err_outst = 0, err_cmdrdy = 0, err_aw = 0, err_w = 0, err_ar = 0;
  logic        pend_aw = 1'b0, pend_w = 1'b0, pend_ar = 1'b0;
  logic [5:0]  pend_awaddr = 6'd0, pend_araddr = 6'd0;
  logic [31:0] pend_wdata = 32'd0;

  always @(posedge clk) begin
    if (!aresetn) out_cnt <= 0;
    else if (cmd_valid && cmd_ready) begin
      if (out_cnt != 0) err_outst <= err_outst + 1;
      out_cnt <= out_cnt + 1;
    end else if (rsp_valid && rsp_ready) out_cnt <= out_cnt - 1;
    if (aresetn && out_cnt != 0 && cmd_ready) err_cmdrdy <= err_cmdrdy + 1;
    if (pend_aw && (!awvalid || awaddr != pend_awaddr)) err_aw <= err_aw + 1;
    if (pend_w && (!wvalid || wdata != pend_wdata)) err_w <= err_w + 1;
    if (pend_ar && (!arvalid || araddr != pend_araddr)) err_ar <= err_ar + 1;
    pend_aw <= aresetn && awvalid && !awready; pend_awaddr <= awaddr;
    pend_w  <= aresetn && wvalid && !wready;   pend_wdata  <= wdata;
    pend_ar <= aresetn && arvalid && !arready; pend_araddr <= araddr;
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic w; logic [31:0] d; logic [1:0] r; } exp_t;
  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [31:0] exp_mem [0:15];
  int          rsp_seen = 0, split_cnt = 0;

  always @(negedge clk) begin
    if (rsp_valid) rsp_seen++;
    if (!awvalid && wvalid) split_cnt++;
    if (aresetn && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) check("sb_unexpected_rsp", 64'd1, 64'd0);
      else begin
        sb_e = sb_q.pop_front();
        check("rsp_write", {63'd0, rsp_write}, {63'd0, sb_e.w});
        check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, sb_e.d});
        check("rsp_resp", {62'd0, rsp_resp}, {62'd0, sb_e.r});
      end
    end
  end

  task automatic issue(input logic w, input logic [5:0] a, input logic [31:0] d,
                       input logic [1:0] exp_resp);
    exp_t e;
    int t;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 60) begin @(negedge clk); t++; end
    if (!cmd_ready) check("cmd_accept_timeout", 64'd0, 64'd1);
    else begin
      e.w = w;
      e.d = w ? 32'd0 : exp_mem[a[5:2]];
      e.r = w ? exp_resp : 2'b00;
      if (w) exp_mem[a[5:2]] = d;
      sb_q.push_back(e);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    if (sb_q.size() != 0) check(tag, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [6:0] vr_outs();
    return {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid};
  endfunction

  int lat, aw0, w0, b0, ar0, t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 6'd0;
    cmd_wdata = 32'd0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_vr_outs", {57'd0, vr_outs()}, 64'd0);
    check("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("reset_awaddr", {58'd0, awaddr}, 64'd0);
    @(posedge clk); #1 aresetn = 1'b1;
    @(posedge clk); @(negedge clk);
    check("cmd_ready_after_reset", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;

    // 1: write with minimum latency
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    issue(1'b1, 6'h02, 32'hDEADBEEF, 2'b00);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    check("wr_latency", 64'(lat), 64'd3);
    wait_idle("t1_rsp_timeout");
    check("t1_aw_hs", 64'(aw_hs - aw0), 64'd1);
    check("t1_w_hs", 64'(w_hs - w0), 64'd1);
    check("t1_b_hs", 64'(b_hs - b0), 64'd1);

    // 2: read back
    ar0 = ar_hs;
    issue(1'b0, 6'h02, 32'd0, 2'b00);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    check("rd_latency", 64'(lat), 64'd3);
    wait_idle("t2_rsp_timeout");
    check("t2_ar_hs", 64'(ar_hs - ar0), 64'd1);

    // 3: awready three cycles ahead of wready, error response captured
    aw_delay = 0; w_delay = 3; b_resp_cfg = 2'b10;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; split_cnt = 0;
    issue(1'b1, 6'h10, 32'h12345678, 2'b10);
    wait_idle("t3_rsp_timeout");
    check("t3_aw_low_w_high_cycles", 64'(split_cnt), 64'd3);
    check("t3_aw_hs", 64'(aw_hs - aw0), 64'd1);
    check("t3_w_hs", 64'(w_hs - w0), 64'd1);
    check("t3_b_hs", 64'(b_hs - b0), 64'd1);
    w_delay = 0; b_resp_cfg = 2'b00;

    // 4: response stalled by consumer, new command must be ignored
    rsp_ready = 1'b0;
    issue(1'b0, 6'h10, 32'd0, 2'b00);
    t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    check("t4_rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    @(posedge clk); #1;
    aw0 = aw_hs;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h20; cmd_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_rsp_valid_held", {63'd0, rsp_valid}, 64'd1);
      check("t4_rsp_rdata_stable", {32'd0, rsp_rdata}, {32'd0, 32'h12345678});
      check("t4_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    end
    @(posedge clk); #1 cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle("t4_rsp_timeout");
    check("t4_no_aw_from_ignored_cmd", 64'(aw_hs - aw0), 64'd0);

    // 5: reset while waiting for B
    b_block = 1'b1;
    issue(1'b1, 6'h30, 32'hCAFEF00D, 2'b00);
    t = 0;
    while (!bready && t < 20) begin @(negedge clk); t++; end
    check("t5_in_wr_b", {63'd0, bready}, 64'd1);
    rsp_seen = 0;
    @(posedge clk); #1 aresetn = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t5_vr_outs_in_reset", {57'd0, vr_outs()}, 64'd0);
    @(posedge clk); #1 aresetn = 1'b1; b_block = 1'b0;
    sb_q.delete();
    @(posedge clk); @(negedge clk);
    check("t5_cmd_ready_after_release", {63'd0, cmd_ready}, 64'd1);
    repeat (3) @(negedge clk);
    check("t5_no_rsp", 64'(rsp_seen), 64'd0);
    @(posedge clk); #1;

    // 6: back-to-back writes then reads
    for (int i = 0; i < 4; i++) issue(1'b1, 6'(i * 4), 32'hA5A50000 + 32'(i), 2'b00);
    wait_idle("t6_wr_timeout");
    for (int i = 0; i < 4; i++) issue(1'b0, 6'(i * 4), 32'd0, 2'b00);
    wait_idle("t6_rd_timeout");

    check("protocol_errors", 64'(err_outst + err_cmdrdy + err_aw + err_w + err_ar), 64'd0);
    check("sb_left", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
